// File: rtl/reset_pkg.sv
// reset_pkg
// Shared definitions for the reset sequencer: the FSM state type and its
// fixed encoding. The encoding is visible on the debug port `state`, so the
// numeric values are pinned here rather than left to the enum default.
package reset_pkg;

    localparam logic [1:0] ST_HOLD    = 2'd0;
    localparam logic [1:0] ST_STRETCH = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;
    localparam logic [1:0] ST_RUN     = 2'd3;

    typedef enum logic [1:0] {
        HOLD    = ST_HOLD,
        STRETCH = ST_STRETCH,
        RELEASE = ST_RELEASE,
        RUN     = ST_RUN
    } state_t;

endpackage

// File: rtl/sync2.sv
// sync2
// Generic two-flop synchronizer for a single-bit level signal.
// Ports:
//   clk   - destination clock
//   reset - asynchronous, active-high; clears both flops to 0
//   d     - asynchronous input
//   q     - synchronised output (two clk edges of latency)
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer
// Turns a raw PLL-lock indication into CHANNELS staged reset outputs. All
// channels are held in reset until lock has been stable for STRETCH_CYCLES,
// then released one at a time (bit 0 first) every STAGE_GAP cycles. Lock loss
// or a software request re-asserts every channel and restarts the sequence.
//
// Optional feature (macro RESET_WATCHDOG_EN): a watchdog that, while in RUN,
// forces a full re-sequence unless wdt_kick arrives within WDT_CYCLES cycles,
// and sets the sticky wdt_fired flag. Without the macro wdt_kick is ignored
// and wdt_fired is tied low.
//
// Ports:
//   clk              - PLL output clock
//   reset            - asynchronous, active-high
//   pll_locked_async - raw lock, asynchronous to clk
//   sw_reset_req     - synchronous re-sequence request (held high keeps HOLD)
//   wdt_kick         - synchronous watchdog kick
//   reset_out        - per-channel active-high resets, bit 0 released first
//   state            - current FSM state (HOLD/STRETCH/RELEASE/RUN = 0..3)
//   done             - high in RUN
//   wdt_fired        - sticky watchdog-expiry flag
module reset_sequencer
    import reset_pkg::*;
#(
    parameter int CHANNELS       = 4,
    parameter int STRETCH_CYCLES = 15,
    parameter int STAGE_GAP      = 4,
    parameter int WDT_CYCLES     = 1048576
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pll_locked_async,
    input  logic                sw_reset_req,
    input  logic                wdt_kick,
    output logic [CHANNELS-1:0] reset_out,
    output logic [1:0]          state,
    output logic                done,
    output logic                wdt_fired
);

    localparam int STRETCH_W = $clog2(STRETCH_CYCLES + 1);
    localparam int GAP_W     = $clog2(STAGE_GAP + 1);
    localparam int IDX_W     = $clog2(CHANNELS) + 1;

    localparam logic [STRETCH_W-1:0] STRETCH_LAST = STRETCH_W'(STRETCH_CYCLES - 1);
    localparam logic [GAP_W-1:0]     GAP_LAST     = GAP_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0]     IDX_LAST     = IDX_W'(CHANNELS - 1);

    state_t                state_q;
    logic [CHANNELS-1:0]   reset_out_q;
    logic                  done_q;
    logic [STRETCH_W-1:0]  stretch_cnt;
    logic [GAP_W-1:0]      gap_cnt;
    logic [IDX_W-1:0]      ch_idx;
    logic                  locked_s;
    logic                  abort;
    logic                  wdt_expire;

    sync2 u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pll_locked_async),
        .q     (locked_s)
    );

    // Lock loss and software request outrank everything except reset.
    assign abort = !locked_s || sw_reset_req;

`ifdef RESET_WATCHDOG_EN
    localparam int WDT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

    logic [WDT_W-1:0] wdt_cnt;
    logic             wdt_fired_q;

    // A kick on the expiry cycle wins: the count simply restarts.
    assign wdt_expire = (state_q == RUN) && !wdt_kick && (wdt_cnt == WDT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdt_cnt     <= '0;
            wdt_fired_q <= 1'b0;
        end else begin
            if ((state_q != RUN) || abort || wdt_kick || wdt_expire)
                wdt_cnt <= '0;
            else
                wdt_cnt <= wdt_cnt + WDT_W'(1);
            if (wdt_expire && !abort)
                wdt_fired_q <= 1'b1;
        end
    end

    assign wdt_fired = wdt_fired_q;
`else
    logic unused_wdt;
    assign unused_wdt = wdt_kick ^ (WDT_CYCLES == 0);
    assign wdt_expire = 1'b0;
    assign wdt_fired  = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= HOLD;
            reset_out_q <= '1;
            done_q      <= 1'b0;
            stretch_cnt <= '0;
            gap_cnt     <= '0;
            ch_idx      <= '0;
        end else if (abort || wdt_expire) begin
            state_q     <= HOLD;
            reset_out_q <= '1;
            done_q      <= 1'b0;
            stretch_cnt <= '0;
            gap_cnt     <= '0;
            ch_idx      <= '0;
        end else begin
            case (state_q)
                HOLD: begin
                    // locked_s is known high here, otherwise abort fired.
                    state_q     <= STRETCH;
                    stretch_cnt <= '0;
                end
                STRETCH: begin
                    if (stretch_cnt == STRETCH_LAST) begin
                        stretch_cnt    <= '0;
                        gap_cnt        <= '0;
                        reset_out_q[0] <= 1'b0;
                        if (CHANNELS == 1) begin
                            state_q <= RUN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RELEASE;
                            ch_idx  <= IDX_W'(1);
                        end
                    end else begin
                        stretch_cnt <= stretch_cnt + STRETCH_W'(1);
                    end
                end
                RELEASE: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        for (int i = 0; i < CHANNELS; i++) begin
                            if (i == int'(ch_idx))
                                reset_out_q[i] <= 1'b0;
                        end
                        ch_idx <= ch_idx + IDX_W'(1);
                        if (ch_idx == IDX_LAST) begin
                            state_q <= RUN;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                RUN: begin
                    reset_out_q <= '0;
                    done_q      <= 1'b1;
                end
                default: begin
                    state_q     <= HOLD;
                    reset_out_q <= '1;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

    assign reset_out = reset_out_q;
    assign state     = state_q;
    assign done      = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
// Bench for reset_sequencer with default sequencing parameters. The reference
// model tracks k, the number of consecutive "clean" edges (synchronised lock
// high, no software request) since the last abort; every expected output is a
// closed-form function of k. Define RESET_WATCHDOG_EN to build and exercise
// the watchdog (instance uses WDT_CYCLES=16).
module tb_reset_sequencer;

    localparam int CH    = 4;
    localparam int S     = 15;
    localparam int G     = 4;
    localparam int WDT   = 16;
    localparam int K_RUN = 1 + S + (CH - 1) * G;

    logic          clk = 1'b0;
    logic          reset;
    logic          pll_locked_async;
    logic          sw_reset_req;
    logic          wdt_kick;
    logic [CH-1:0] reset_out;
    logic [1:0]    state;
    logic          done;
    logic          wdt_fired;

    int checks   = 0;
    int failures = 0;

    // reference model state
    int k;
    int w;
    bit s1, s2;
    bit fired;

    always #5 clk = ~clk;

    reset_sequencer #(
        .CHANNELS       (CH),
        .STRETCH_CYCLES (S),
        .STAGE_GAP      (G),
        .WDT_CYCLES     (WDT)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .pll_locked_async (pll_locked_async),
        .sw_reset_req     (sw_reset_req),
        .wdt_kick         (wdt_kick),
        .reset_out        (reset_out),
        .state            (state),
        .done             (done),
        .wdt_fired        (wdt_fired)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [CH-1:0] exp_rst();
        logic [CH-1:0] r;
        for (int j = 0; j < CH; j++) r[j] = !(k >= 1 + S + j * G);
        return r;
    endfunction

    function automatic logic [1:0] exp_state();
        if (k == 0)      return 2'd0;
        if (k < 1 + S)   return 2'd1;
        if (k < K_RUN)   return 2'd2;
        return 2'd3;
    endfunction

    // Advance the model by one clock edge using the inputs as sampled there.
    task automatic model_edge();
        bit clean;
        if (reset) begin
            k = 0; w = 0; s1 = 0; s2 = 0; fired = 0;
            return;
        end
        clean = s2 && !sw_reset_req;
        if (!clean) begin
            k = 0;
            w = 0;
        end else begin
`ifdef RESET_WATCHDOG_EN
            if (k >= K_RUN) begin
                if (wdt_kick) w = 0;
                else if (w == WDT - 1) begin
                    k = 0; w = 0; fired = 1;
                end else w++;
            end else begin
                k++;
                w = 0;
            end
`else
            if (k < K_RUN) k++;
`endif
        end
        s2 = s1;
        s1 = pll_locked_async;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "/reset_out"}, 32'(reset_out), 32'(exp_rst()));
        chk({tag, "/state"},     32'(state),     32'(exp_state()));
        chk({tag, "/done"},      32'(done),      32'(k >= K_RUN));
        chk({tag, "/wdt_fired"}, 32'(wdt_fired), 32'(fired));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    task automatic run(input int n, input string tag);
        repeat (n) step(tag);
    endtask

    task automatic sw_pulse(input string tag);
        sw_reset_req = 1'b1;
        step(tag);
        sw_reset_req = 1'b0;
    endtask

    initial begin
        reset = 1'b1; pll_locked_async = 1'b0; sw_reset_req = 1'b0; wdt_kick = 1'b0;
        k = 0; w = 0; s1 = 0; s2 = 0; fired = 0;
        #1;
        check_model("por");
        run(2, "in_reset");
        reset = 1'b0;

        // nominal sequence with explicit release edges
        run(5, "pre_lock");
        pll_locked_async = 1'b1;
        for (int n = 1; n <= 32; n++) begin
            step("nominal");
            if (n == 17) chk("edge17_rst", 32'(reset_out), 32'h0f);
            if (n == 18) chk("edge18_rst", 32'(reset_out), 32'h0e);
            if (n == 22) chk("edge22_rst", 32'(reset_out), 32'h0c);
            if (n == 26) chk("edge26_rst", 32'(reset_out), 32'h08);
            if (n == 29) chk("edge29_done", 32'(done), 32'h0);
            if (n == 30) begin
                chk("edge30_rst",  32'(reset_out), 32'h00);
                chk("edge30_done", 32'(done), 32'h1);
            end
        end

        // lock glitch while stretching (counter at 10)
        pll_locked_async = 1'b0;
        run(5, "drop");
        pll_locked_async = 1'b1;
        run(13, "stretch");
        chk("stretch_state", 32'(state), 32'h1);
        pll_locked_async = 1'b0;
        run(3, "glitch");
        pll_locked_async = 1'b1;
        for (int n = 1; n <= 18; n++) begin
            step("restretch");
            if (n == 2)  chk("restretch_hold", 32'(state), 32'h0);
            if (n == 17) chk("restretch17", 32'(reset_out), 32'h0f);
            if (n == 18) chk("restretch18", 32'(reset_out), 32'h0e);
        end
        run(15, "to_run");

        // lock loss in RUN
        pll_locked_async = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            step("run_loss");
            if (n == 2) chk("loss2_done", 32'(done), 32'h1);
            if (n == 3) begin
                chk("loss3_rst",  32'(reset_out), 32'h0f);
                chk("loss3_done", 32'(done), 32'h0);
            end
        end
        pll_locked_async = 1'b1;
        run(32, "relock");

        // software request mid-RELEASE
        sw_pulse("sw1");
        run(21, "sw_seq");
        chk("pre_sw_rst", 32'(reset_out), 32'h0c);
        sw_pulse("sw2");
        chk("sw_rst",   32'(reset_out), 32'h0f);
        chk("sw_state", 32'(state), 32'h0);
        run(30, "sw_reseq");
        sw_reset_req = 1'b1;
        run(5, "sw_held");
        sw_reset_req = 1'b0;

        // asynchronous reset mid-RELEASE
        run(22, "pre_async");
        #3;
        reset = 1'b1;
        #1;
        k = 0; w = 0; s1 = 0; s2 = 0; fired = 0;
        chk("async_rst",   32'(reset_out), 32'h0f);
        chk("async_state", 32'(state), 32'h0);
        chk("async_done",  32'(done), 32'h0);
        run(2, "async_held");
        reset = 1'b0;
        run(35, "after_async");

`ifdef RESET_WATCHDOG_EN
        // no kicks: expiry 16 edges after RUN entry
        sw_pulse("wdt_a");
        run(K_RUN, "wdt_seq");
        chk("wdt_in_run", 32'(state), 32'h3);
        run(15, "wdt_wait");
        chk("wdt_pre", 32'(wdt_fired), 32'h0);
        step("wdt_exp");
        chk("wdt_exp_state", 32'(state), 32'h0);
        chk("wdt_exp_fired", 32'(wdt_fired), 32'h1);
        // regular kicks keep RUN
        run(K_RUN + 1, "wdt_reseq");
        for (int i = 0; i < 60; i++) begin
            wdt_kick = (i % 8 == 0);
            step("wdt_kick");
        end
        wdt_kick = 1'b0;
        chk("wdt_kept_run", 32'(state), 32'h3);
`endif

        // randomized phase
        for (int i = 0; i < 800; i++) begin
            if (pll_locked_async) begin
                if ($urandom_range(0, 59) == 0) pll_locked_async = 1'b0;
            end else begin
                if ($urandom_range(0, 3) == 0) pll_locked_async = 1'b1;
            end
            sw_reset_req = ($urandom_range(0, 79) == 0);
            wdt_kick     = ($urandom_range(0, 9) == 0);
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
